attack_sched: RTL and testbench

Time-multiplexed scheduler that shares one envelope attack-shaping table among all FM operator slots of the VM2413 core. It holds a per-slot 22-bit attack phase accumulator and visits slots round-robin, one per `clkena` cycle. On each visit it drives the table address from the visited slot's phase. It tags results through the table's two-stage latency and returns slot-tagged attack levels to the envelope generator.

---
 rtl/attack_sched.sv | 153 +++++++++++++++
 tb/tb_attack_sched.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/attack_sched.sv
// Round-robin attack-phase scheduler: shares one two-stage attack table among SLOTS
// operator slots and returns slot-tagged attack levels.
module attack_sched #(
  parameter int SLOTS = 18,
  parameter int AW    = 22,
  parameter int DW    = 13
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clkena,
  input  logic             start_valid,
  input  logic [4:0]       start_slot,
  input  logic [AW-1:0]    start_rate,
  input  logic             abort_valid,
  input  logic [4:0]       abort_slot,
  output logic [AW-1:0]    tbl_addr,
  input  logic [DW-1:0]    tbl_data,
  output logic [SLOTS-1:0] busy,
  output logic             out_valid,
  output logic [4:0]       out_slot,
  output logic [DW-1:0]    out_data,
  output logic             out_done
);

  typedef enum logic {S_IDLE = 1'b0, S_ATTACK = 1'b1} slot_state_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] slot;
    logic       done;
  } tag_t;

  localparam logic [AW-1:0] PHASE_MAX = {AW{1'b1}};
  localparam logic [4:0]    PTR_LAST  = 5'(SLOTS - 1);

  slot_state_e   state_q [SLOTS];
  slot_state_e   state_d [SLOTS];
  logic [AW-1:0] phase_q [SLOTS];
  logic [AW-1:0] phase_d [SLOTS];
  logic [AW-1:0] rate_q  [SLOTS];
  logic [AW-1:0] rate_d  [SLOTS];
  logic [4:0]    ptr_q, ptr_d;

  tag_t          tag1_q, tag1_d;
  tag_t          tag2_q, tag2_d;
  logic          out_valid_q, out_valid_d;
  logic [4:0]    out_slot_q, out_slot_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_done_q, out_done_d;

  logic          vis_busy;
  logic [AW-1:0] vis_phase;
  logic [AW-1:0] vis_rate;
  logic [AW:0]   vis_sum;
  logic [AW-1:0] vis_next;
  logic          vis_done;

  // Visit, then start, then abort: later assignments in the loop take precedence.
  always_comb begin
    ptr_d     = (ptr_q == PTR_LAST) ? 5'd0 : ptr_q + 5'd1;
    state_d   = state_q;
    phase_d   = phase_q;
    rate_d    = rate_q;
    vis_busy  = 1'b0;
    vis_phase = '0;
    vis_rate  = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (ptr_q == 5'(i)) begin
        vis_busy  = (state_q[i] == S_ATTACK);
        vis_phase = phase_q[i];
        vis_rate  = rate_q[i];
      end
    end
    vis_done = vis_busy && (vis_phase == PHASE_MAX);
    vis_sum  = {1'b0, vis_phase} + {1'b0, vis_rate};
    vis_next = vis_sum[AW] ? PHASE_MAX : vis_sum[AW-1:0];
    tbl_addr = vis_busy ? vis_phase : '0;

    for (int i = 0; i < SLOTS; i++) begin
      if (vis_busy && ptr_q == 5'(i)) begin
        if (vis_done) state_d[i] = S_IDLE;
        else          phase_d[i] = vis_next;
      end
      if (start_valid && start_slot == 5'(i)) begin
        state_d[i] = S_ATTACK;
        phase_d[i] = '0;
        rate_d[i]  = start_rate;
      end
      if (abort_valid && abort_slot == 5'(i)) begin
        state_d[i] = S_IDLE;
        phase_d[i] = '0;
      end
    end
  end

  // Tags track the table's two-stage latency; output fields hold between results.
  always_comb begin
    tag1_d.valid = vis_busy;
    tag1_d.slot  = ptr_q;
    tag1_d.done  = vis_done;
    tag2_d       = tag1_q;
    out_valid_d  = tag2_q.valid;
    out_slot_d   = out_slot_q;
    out_data_d   = out_data_q;
    out_done_d   = out_done_q;
    if (tag2_q.valid) begin
      out_slot_d = tag2_q.slot;
      out_data_d = tbl_data;
      out_done_d = tag2_q.done;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q       <= '0;
      tag1_q      <= '0;
      tag2_q      <= '0;
      out_valid_q <= 1'b0;
      out_slot_q  <= '0;
      out_data_q  <= '0;
      out_done_q  <= 1'b0;
      for (int i = 0; i < SLOTS; i++) begin
        state_q[i] <= S_IDLE;
        phase_q[i] <= '0;
        rate_q[i]  <= '0;
      end
    end else if (clkena) begin
      ptr_q       <= ptr_d;
      state_q     <= state_d;
      phase_q     <= phase_d;
      rate_q      <= rate_d;
      tag1_q      <= tag1_d;
      tag2_q      <= tag2_d;
      out_valid_q <= out_valid_d;
      out_slot_q  <= out_slot_d;
      out_data_q  <= out_data_d;
      out_done_q  <= out_done_d;
    end
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < SLOTS; i++) begin
      busy[i] = (state_q[i] == S_ATTACK);
    end
  end

  assign out_valid = out_valid_q;
  assign out_slot  = out_slot_q;
  assign out_data  = out_data_q;
  assign out_done  = out_done_q;

endmodule

// File: tb/tb_attack_sched.sv
// Bench for attack_sched: a two-stage stand-in attack table, a result scoreboard
// fed by the directed scenarios, and a final summary.
module tb_attack_sched;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clkena;
  logic        start_valid;
  logic [4:0]  start_slot;
  logic [21:0] start_rate;
  logic        abort_valid;
  logic [4:0]  abort_slot;
  logic [21:0] tbl_addr;
  logic [12:0] tbl_data;
  logic [17:0] busy;
  logic        out_valid;
  logic [4:0]  out_slot;
  logic [12:0] out_data;
  logic        out_done;

  attack_sched dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .clkena      (clkena),
    .start_valid (start_valid),
    .start_slot  (start_slot),
    .start_rate  (start_rate),
    .abort_valid (abort_valid),
    .abort_slot  (abort_slot),
    .tbl_addr    (tbl_addr),
    .tbl_data    (tbl_data),
    .busy        (busy),
    .out_valid   (out_valid),
    .out_slot    (out_slot),
    .out_data    (out_data),
    .out_done    (out_done)
  );

  // ---------------- clock / reset bookkeeping ----------------
  always #5 clk = ~clk;

  int   cyc;
  logic en_edge;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cyc     <= 0;
      en_edge <= 1'b0;
    end else begin
      en_edge <= clkena;
      if (clkena) cyc <= cyc + 1;
    end
  end

  // ---------------- attack table model ----------------
  function automatic logic [12:0] tbl_fn(input logic [21:0] a);
    case (a)
      22'h000000: tbl_fn = 13'd0;
      22'h200000: tbl_fn = 13'd1152;
      22'h3FFFFF: tbl_fn = 13'd8128;
      default:    tbl_fn = a[12:0] ^ a[21:9];
    endcase
  endfunction

  logic [12:0] t1, t2;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      t1 <= '0;
      t2 <= '0;
    end else if (clkena) begin
      t1 <= tbl_fn(tbl_addr);
      t2 <= t1;
    end
  end
  assign tbl_data = t2;

  // ---------------- scoreboard ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  logic [18:0] exp_q[$];
  int          out_cyc_q[$];
  logic [18:0] mon_item;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [18:0] pack(input logic [4:0] s, input logic [12:0] d, input logic dn);
    return {s, d, dn};
  endfunction

  always @(negedge clk) begin
    if (reset_n && en_edge && out_valid) begin
      out_cyc_q.push_back(cyc);
      chk("out_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_item = exp_q.pop_front();
        chk("out_tag", {13'd0, out_slot, out_data, out_done}, {13'd0, mon_item});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic sv, input logic [4:0] ss, input logic [21:0] sr,
                       input logic av, input logic [4:0] a_slot);
    start_valid = sv;
    start_slot  = ss;
    start_rate  = sr;
    abort_valid = av;
    abort_slot  = a_slot;
    @(negedge clk);
    start_valid = 1'b0;
    abort_valid = 1'b0;
  endtask

  task automatic wait_ptr(input int p);
    int n = 0;
    while ((cyc % 18) != p && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("wait_ptr", 32'((cyc % 18) == p), 32'd1);
  endtask

  task automatic wait_cyc(input int c);
    int n = 0;
    while (cyc != c && n < 80) begin
      @(negedge clk);
      n++;
    end
    chk("wait_cyc", 32'(cyc), 32'(c));
  endtask

  task automatic wait_q(input int sz, input int bound);
    int n = 0;
    while (exp_q.size() > sz && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("wait_q", 32'(exp_q.size()), 32'(sz));
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  int fall_cyc;

  initial begin
    reset_n     = 1'b0;
    clkena      = 1'b1;
    start_valid = 1'b0;
    start_slot  = '0;
    start_rate  = '0;
    abort_valid = 1'b0;
    abort_slot  = '0;
    idle(2);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_slot", out_slot, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_done", out_done, 0);
    chk("rst_tbl_addr", tbl_addr, 0);
    reset_n = 1'b1;

    // Reset mid-attack: slot 5 has a lookup in flight when reset hits.
    drive(1'b1, 5'd5, 22'h080000, 1'b0, 5'd0);
    chk("s5_busy", busy[5], 1);
    exp_q.push_back(pack(5'd5, tbl_fn(22'h000000), 1'b0));
    wait_cyc(23);
    chk("s5_addr_round2", tbl_addr, 22'h080000);
    wait_cyc(24);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_tbl_addr", tbl_addr, 0);
    idle(2);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("postrst_no_out", out_valid, 0);
    end

    // Full attack on slot 3: 0 -> 0x200000 -> saturate -> done.
    out_cyc_q.delete();
    fall_cyc = -1;
    drive(1'b1, 5'd3, 22'h200000, 1'b0, 5'd0);
    chk("s3_busy_set", busy[3], 1);
    exp_q.push_back(pack(5'd3, 13'd0, 1'b0));
    exp_q.push_back(pack(5'd3, 13'd1152, 1'b0));
    exp_q.push_back(pack(5'd3, 13'd8128, 1'b1));
    for (int n = 0; n < 80 && exp_q.size() > 0; n++) begin
      @(negedge clk);
      if (!busy[3] && fall_cyc < 0) fall_cyc = cyc;
    end
    chk("s3_drained", 32'(exp_q.size()), 0);
    chk("s3_out_count", 32'(out_cyc_q.size()), 3);
    if (out_cyc_q.size() == 3) begin
      chk("s3_gap1", 32'(out_cyc_q[1] - out_cyc_q[0]), 18);
      chk("s3_gap2", 32'(out_cyc_q[2] - out_cyc_q[1]), 18);
      chk("s3_busy_fall", 32'(out_cyc_q[2] - fall_cyc), 2);
    end

    // Abort slot 3 one cycle after its first lookup; that result still arrives.
    drive(1'b1, 5'd3, 22'h100000, 1'b0, 5'd0);
    wait_ptr(3);
    exp_q.push_back(pack(5'd3, tbl_fn(22'h000000), 1'b0));
    @(negedge clk);
    drive(1'b0, 5'd0, 22'h0, 1'b1, 5'd3);
    chk("abort_busy", busy[3], 0);
    wait_q(0, 20);
    idle(40);
    chk("abort_busy_late", busy[3], 0);

    // Start and abort of slot 7 on one edge: abort wins.
    drive(1'b1, 5'd7, 22'h100000, 1'b1, 5'd7);
    chk("s7_busy", busy[7], 0);
    idle(40);
    chk("s7_busy_late", busy[7], 0);

    // Out-of-range slot numbers are ignored.
    drive(1'b1, 5'd20, 22'h100000, 1'b0, 5'd0);
    chk("oor_start", busy, 0);

    // Slots 17 and 0 across the pointer wrap, with clkena 1,0,0,1.
    wait_ptr(1);
    drive(1'b1, 5'd17, 22'h200000, 1'b0, 5'd0);
    drive(1'b1, 5'd0, 22'h200000, 1'b0, 5'd0);
    out_cyc_q.delete();
    exp_q.push_back(pack(5'd17, 13'd0, 1'b0));
    exp_q.push_back(pack(5'd0, 13'd0, 1'b0));
    exp_q.push_back(pack(5'd17, 13'd1152, 1'b0));
    exp_q.push_back(pack(5'd0, 13'd1152, 1'b0));
    exp_q.push_back(pack(5'd17, 13'd8128, 1'b1));
    exp_q.push_back(pack(5'd0, 13'd8128, 1'b1));
    wait_q(4, 60);
    wait_ptr(17);
    @(negedge clk);
    clkena = 1'b0;
    chk("frz_addr0", tbl_addr, 22'h200000);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("frz_addr", tbl_addr, 22'h200000);
      chk("frz_busy", busy, 18'h20001);
    end
    clkena = 1'b1;
    wait_q(0, 80);
    chk("wrap_out_count", 32'(out_cyc_q.size()), 6);
    if (out_cyc_q.size() == 6) begin
      chk("wrap_consec_r1", 32'(out_cyc_q[1] - out_cyc_q[0]), 1);
      chk("wrap_consec_r2", 32'(out_cyc_q[3] - out_cyc_q[2]), 1);
    end
    chk("wrap_busy_clear", busy, 0);

    // Rate 0 never completes.
    out_cyc_q.delete();
    drive(1'b1, 5'd9, 22'h0, 1'b0, 5'd0);
    for (int i = 0; i < 3; i++) exp_q.push_back(pack(5'd9, 13'd0, 1'b0));
    wait_q(0, 80);
    chk("r0_busy", busy[9], 1);
    if (out_cyc_q.size() == 3) begin
      chk("r0_gap", 32'(out_cyc_q[2] - out_cyc_q[1]), 18);
    end
    drive(1'b0, 5'd0, 22'h0, 1'b1, 5'd9);
    chk("r0_abort", busy[9], 0);

    idle(40);
    chk("final_q_empty", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
